// File: rtl/portas_ocupacao.sv
// Multi-door access controller: one FSM per door, shared occupancy counter and
// capacity-limited entry grant. Lamps, buzzer and turnstile direction are Moore outputs.
module portas_ocupacao #(
  parameter int NDOOR       = 2,
  parameter int MAX_OCC     = 8,
  parameter int TIMEOUT_CYC = 16,
  localparam int CW         = $clog2(MAX_OCC + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NDOOR-1:0]   entra,
  input  logic [NDOOR-1:0]   sai,
  input  logic [NDOOR-1:0]   sensor,
  output logic [CW-1:0]      occ,
  output logic               full,
  output logic               occ_err,
  output logic [2*NDOOR-1:0] dir,
  output logic [NDOOR-1:0]   verde,
  output logic [NDOOR-1:0]   vermelho,
  output logic [NDOOR-1:0]   som,
  output logic [3*NDOOR-1:0] estado
);

  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int XW = CW + 4;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    OPEN_IN    = 3'd1,
    OPEN_OUT   = 3'd2,
    CONFLICT   = 3'd3,
    DENIED     = 3'd4,
    TIMEOUT    = 3'd5,
    WAIT_CLEAR = 3'd6
  } st_t;

  logic [CW-1:0]    occ_reg, occ_next;
  logic             occ_err_reg, err_set;
  logic [NDOOR-1:0] sensor_q;
  logic [NDOOR-1:0] pe, grant, in_open_in, entry_req, cross_in, cross_out;

  assign pe = sensor & ~sensor_q;

  // Doors already holding an OPEN_IN slot reserve capacity; new grants go lowest index first.
  always_comb begin
    logic [XW-1:0] res, given;
    res   = '0;
    given = '0;
    grant = '0;
    for (int i = 0; i < NDOOR; i++)
      if (in_open_in[i]) res = res + XW'(1);
    for (int i = 0; i < NDOOR; i++) begin
      if ((XW'(occ_reg) + res + given) < XW'(MAX_OCC)) grant[i] = 1'b1;
      if (grant[i] && entry_req[i]) given = given + XW'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NDOOR; gi++) begin : g_door
      st_t           state_reg, state_next;
      logic [TW-1:0] timer_reg;
      logic          e, s, p;

      assign e = entra[gi];
      assign s = sai[gi];
      assign p = sensor[gi];

      always_ff @(posedge clk) begin
        if (rst) begin
          state_reg <= IDLE;
          timer_reg <= '0;
        end else begin
          state_reg <= state_next;
          // OPEN_* is only ever entered from a non-OPEN state, so the timer is already 0 on entry.
          if (state_reg == OPEN_IN || state_reg == OPEN_OUT) timer_reg <= timer_reg + TW'(1);
          else                                                timer_reg <= '0;
        end
      end

      always_comb begin
        state_next = state_reg;
        case (state_reg)
          IDLE: begin
            if (e && !s)      state_next = grant[gi] ? OPEN_IN : DENIED;
            else if (!e && s) state_next = OPEN_OUT;
            else if (e && s)  state_next = CONFLICT;
          end
          OPEN_IN, OPEN_OUT: begin
            if (pe[gi])                                  state_next = WAIT_CLEAR;
            else if (timer_reg == TW'(TIMEOUT_CYC - 1))  state_next = TIMEOUT;
          end
          CONFLICT: begin
            if (!e && s)       state_next = OPEN_OUT;
            else if (!e && !s) state_next = IDLE;
          end
          DENIED, TIMEOUT: if (!e && !s) state_next = IDLE;
          WAIT_CLEAR:      if (!e && !s && !p) state_next = IDLE;
          default:         state_next = IDLE;
        endcase
      end

      assign in_open_in[gi] = (state_reg == OPEN_IN);
      assign entry_req[gi]  = (state_reg == IDLE) && e && !s;
      assign cross_in[gi]   = (state_reg == OPEN_IN)  && pe[gi];
      assign cross_out[gi]  = (state_reg == OPEN_OUT) && pe[gi];

      assign dir[2*gi +: 2]    = {state_reg == OPEN_OUT, state_reg == OPEN_IN};
      assign verde[gi]         = (state_reg == OPEN_IN) || (state_reg == OPEN_OUT);
      assign vermelho[gi]      = (state_reg == CONFLICT) || (state_reg == DENIED) ||
                                 (state_reg == TIMEOUT);
      assign som[gi]           = (state_reg == TIMEOUT);
      assign estado[3*gi +: 3] = state_reg;
    end
  endgenerate

  // Net in/out crossings of the cycle, clamped to 0..MAX_OCC; going negative flags an error.
  always_comb begin
    logic [XW-1:0]        n_in, n_out;
    logic signed [XW-1:0] sum_s;
    n_in     = '0;
    n_out    = '0;
    err_set  = 1'b0;
    occ_next = occ_reg;
    for (int i = 0; i < NDOOR; i++) begin
      if (cross_in[i])  n_in  = n_in  + XW'(1);
      if (cross_out[i]) n_out = n_out + XW'(1);
    end
    sum_s = signed'(XW'(occ_reg)) + signed'(n_in) - signed'(n_out);
    if (sum_s[XW-1]) begin
      occ_next = '0;
      err_set  = 1'b1;
    end else if (sum_s > signed'(XW'(MAX_OCC))) begin
      occ_next = CW'(MAX_OCC);
    end else begin
      occ_next = sum_s[CW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_reg     <= '0;
      occ_err_reg <= 1'b0;
      sensor_q    <= '0;
    end else begin
      occ_reg     <= occ_next;
      occ_err_reg <= occ_err_reg | err_set;
      sensor_q    <= sensor;
    end
  end

  assign occ     = occ_reg;
  assign occ_err = occ_err_reg;
  assign full    = (occ_reg == CW'(MAX_OCC));

endmodule
